can_frame_tail_tx: RTL and testbench



---
 rtl/can_frame_tail_tx.sv | 163 ++++++++++++++++
 tb/tb_can_frame_tail_tx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/can_frame_tail_tx.sv
// can_frame_tail_tx
//   Drives the CAN frame tail after the last CRC bit: CRC delimiter, ACK slot,
//   ACK delimiter, EOF_BITS of EOF and IFS_BITS of intermission. All tail bits
//   are recessive. RX is read back at every sample point to flag ACK, form
//   and overload conditions.
// Ports:
//   clock, reset  - system clock, asynchronous active-low reset
//   TP, SP        - transmit-point / sample-point strobes from bit timing
//   RX            - bus readback (0 = dominant)
//   start         - one-clock pulse after the last CRC bit
//   TX            - bus drive (always recessive here)
//   busy          - tail in progress (including the pending-start wait)
//   EOF_Flag      - high while in the EOF field
//   frame_ok, ack_error, form_error, overload, done - one-clock status pulses
module can_frame_tail_tx #(
  parameter int EOF_BITS = 7,
  parameter int IFS_BITS = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic TP,
  input  logic SP,
  input  logic RX,
  input  logic start,
  output logic TX,
  output logic busy,
  output logic EOF_Flag,
  output logic frame_ok,
  output logic ack_error,
  output logic form_error,
  output logic overload,
  output logic done
);

  localparam int MAX_BITS = (EOF_BITS > IFS_BITS) ? EOF_BITS : IFS_BITS;
  localparam int CNT_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam logic [CNT_W-1:0] EOF_LAST = CNT_W'(EOF_BITS - 1);
  localparam logic [CNT_W-1:0] IFS_LAST = CNT_W'(IFS_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CRC_DEL,
    ST_ACK_SLOT,
    ST_ACK_DEL,
    ST_EOF,
    ST_IFS
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             pending;
  logic             tx_q;

  assign TX = tx_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pending    <= 1'b0;
      tx_q       <= 1'b1;
      busy       <= 1'b0;
      EOF_Flag   <= 1'b0;
      frame_ok   <= 1'b0;
      ack_error  <= 1'b0;
      form_error <= 1'b0;
      overload   <= 1'b0;
      done       <= 1'b0;
    end else begin
      tx_q       <= 1'b1;
      frame_ok   <= 1'b0;
      ack_error  <= 1'b0;
      form_error <= 1'b0;
      overload   <= 1'b0;
      done       <= 1'b0;

      if (state == ST_IDLE) begin
        if (pending) begin
          // A coincident SP suppresses the TP advance, so entry waits too.
          if (TP && !SP) begin
            state   <= ST_CRC_DEL;
            pending <= 1'b0;
          end
        end else if (start) begin
          pending <= 1'b1;
          busy    <= 1'b1;
        end
      end else if (SP) begin
        // Sample-point checks take priority over a same-clock TP.
        unique case (state)
          ST_CRC_DEL, ST_ACK_DEL: begin
            if (!RX) begin
              form_error <= 1'b1;
              state      <= ST_IDLE;
              cnt        <= '0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end
          end
          ST_ACK_SLOT: begin
            if (RX) begin
              ack_error <= 1'b1;
              state     <= ST_IDLE;
              cnt       <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
          ST_EOF: begin
            if (!RX) begin
              form_error <= 1'b1;
              state      <= ST_IDLE;
              cnt        <= '0;
              busy       <= 1'b0;
              done       <= 1'b1;
              EOF_Flag   <= 1'b0;
            end else if (cnt == EOF_LAST) begin
              frame_ok <= 1'b1;
            end
          end
          ST_IFS: begin
            // Dominant in the last intermission bit is the next SOF: no flag.
            if (!RX && (cnt == '0 || cnt == CNT_W'(1)) && cnt != IFS_LAST) begin
              overload <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (TP) begin
        unique case (state)
          ST_CRC_DEL:  state <= ST_ACK_SLOT;
          ST_ACK_SLOT: state <= ST_ACK_DEL;
          ST_ACK_DEL: begin
            state    <= ST_EOF;
            cnt      <= '0;
            EOF_Flag <= 1'b1;
          end
          ST_EOF: begin
            if (cnt == EOF_LAST) begin
              state    <= ST_IFS;
              cnt      <= '0;
              EOF_Flag <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_IFS: begin
            if (cnt == IFS_LAST) begin
              state <= ST_IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_can_frame_tail_tx.sv
module tb_can_frame_tail_tx;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic TP = 1'b0, SP = 1'b0, RX = 1'b1, start = 1'b0;
  logic TX, busy, EOF_Flag, frame_ok, ack_error, form_error, overload, done;

  can_frame_tail_tx #(.EOF_BITS(7), .IFS_BITS(3)) dut (
    .clock(clock), .reset(reset), .TP(TP), .SP(SP), .RX(RX), .start(start),
    .TX(TX), .busy(busy), .EOF_Flag(EOF_Flag), .frame_ok(frame_ok),
    .ack_error(ack_error), .form_error(form_error), .overload(overload),
    .done(done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Pulse counters, only ever incremented here.
  int n_ok = 0, n_ack = 0, n_form = 0, n_ovl = 0, n_done = 0, n_txbad = 0;
  always @(negedge clock) begin
    if (frame_ok)   n_ok++;
    if (ack_error)  n_ack++;
    if (form_error) n_form++;
    if (overload)   n_ovl++;
    if (done)       n_done++;
    if (TX !== 1'b1) n_txbad++;
  end

  int eof_seen;    // TPs issued while EOF_Flag was high
  logic final_done;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // All stimulus tasks start and end at a negedge.
  task automatic tp_pulse();
    if (EOF_Flag) eof_seen++;
    TP = 1'b1;
    @(negedge clock);
    TP = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic sp_pulse(input logic rx);
    RX = rx;
    SP = 1'b1;
    @(negedge clock);
    SP = 1'b0;
    RX = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Bit index: 0 CRC_DEL, 1 ACK slot, 2 ACK_DEL, 3..9 EOF0..6, 10..12 IFS0..2.
  // dom = bit index where RX is dominant (-1 none); inj = bit index before whose
  // TP a stray start is pulsed (-1 none).
  task automatic run_tail(input logic ack, input int dom, input int inj);
    logic rx;
    eof_seen = 0;
    for (int k = 0; k < 13; k++) begin
      if (k == inj) pulse_start();
      tp_pulse();
      rx = (k == 1) ? ~ack : 1'b1;
      if (k == dom) rx = 1'b0;
      sp_pulse(rx);
    end
    if (EOF_Flag) eof_seen++;
    TP = 1'b1;
    @(negedge clock);
    TP = 1'b0;
    final_done = done;
    repeat (3) @(negedge clock);
  endtask

  typedef struct {
    string name;
    logic  ack;
    int    dom;
    int    exp_ok, exp_ack, exp_form, exp_ovl, exp_eof;
  } vec_t;

  vec_t vecs[10];
  int ok0, ack0, form0, ovl0, done0, tx0;

  initial begin
    vecs[0] = '{"nominal",    1'b1, -1, 1, 0, 0, 0, 7};
    vecs[1] = '{"no_ack",     1'b0, -1, 0, 1, 0, 0, 0};
    vecs[2] = '{"crc_del",    1'b1,  0, 0, 0, 1, 0, 0};
    vecs[3] = '{"ack_del",    1'b1,  2, 0, 0, 1, 0, 0};
    vecs[4] = '{"eof_bit0",   1'b1,  3, 0, 0, 1, 0, 0};
    vecs[5] = '{"eof_bit3",   1'b1,  6, 0, 0, 1, 0, 3};
    vecs[6] = '{"eof_bit6",   1'b1,  9, 0, 0, 1, 0, 6};
    vecs[7] = '{"ifs_bit0",   1'b1, 10, 1, 0, 0, 1, 7};
    vecs[8] = '{"ifs_bit1",   1'b1, 11, 1, 0, 0, 1, 7};
    vecs[9] = '{"ifs_bit2",   1'b1, 12, 1, 0, 0, 0, 7};

    // Reset state while reset is held.
    repeat (3) @(negedge clock);
    check("reset_outputs",
          int'({TX, busy, EOF_Flag, frame_ok, ack_error, form_error, overload, done}),
          int'(8'b1000_0000));
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Strobes in IDLE without a start do nothing.
    ok0 = n_ok; form0 = n_form; done0 = n_done;
    tp_pulse(); sp_pulse(1'b0); tp_pulse(); sp_pulse(1'b1);
    check("idle_strobes_busy", int'(busy), 0);
    check("idle_strobes_pulses", (n_ok - ok0) + (n_form - form0) + (n_done - done0), 0);

    // Table-driven tails.
    foreach (vecs[i]) begin
      ok0 = n_ok; ack0 = n_ack; form0 = n_form; ovl0 = n_ovl; done0 = n_done; tx0 = n_txbad;
      pulse_start();
      check({vecs[i].name, "_busy_after_start"}, int'(busy), 1);
      run_tail(vecs[i].ack, vecs[i].dom, -1);
      check({vecs[i].name, "_frame_ok"},   n_ok - ok0,     vecs[i].exp_ok);
      check({vecs[i].name, "_ack_error"},  n_ack - ack0,   vecs[i].exp_ack);
      check({vecs[i].name, "_form_error"}, n_form - form0, vecs[i].exp_form);
      check({vecs[i].name, "_overload"},   n_ovl - ovl0,   vecs[i].exp_ovl);
      check({vecs[i].name, "_eof_bits"},   eof_seen,       vecs[i].exp_eof);
      check({vecs[i].name, "_done"},       n_done - done0, 1);
      check({vecs[i].name, "_done_on_last_tp"}, int'(final_done), vecs[i].exp_ok);
      check({vecs[i].name, "_busy_end"},   int'(busy),     0);
      check({vecs[i].name, "_tx_recessive"}, n_txbad - tx0, 0);
    end

    // Async reset during EOF bit 4 aborts silently.
    done0 = n_done;
    pulse_start();
    for (int k = 0; k < 7; k++) begin
      tp_pulse();
      sp_pulse((k == 1) ? 1'b0 : 1'b1);
    end
    tp_pulse();  // enter EOF bit 4
    check("rst_pre_eof_flag", int'(EOF_Flag), 1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_outputs",
          int'({TX, busy, EOF_Flag, frame_ok, ack_error, form_error, overload, done}),
          int'(8'b1000_0000));
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    sp_pulse(1'b1); tp_pulse();
    check("rst_no_done", n_done - done0, 0);

    // Nominal tail after reset, with a stray start while busy.
    ok0 = n_ok; done0 = n_done;
    pulse_start();
    run_tail(1'b1, -1, 5);
    check("post_rst_frame_ok", n_ok - ok0, 1);
    check("post_rst_eof_bits", eof_seen, 7);
    check("busy_start_one_done", n_done - done0, 1);
    check("post_rst_busy_end", int'(busy), 0);

    // Coincident TP+SP in the ACK slot: the check wins, the advance is dropped.
    ack0 = n_ack; done0 = n_done;
    pulse_start();
    tp_pulse(); sp_pulse(1'b1);  // CRC_DEL
    tp_pulse();                  // into ACK slot
    RX = 1'b1; TP = 1'b1; SP = 1'b1;
    @(negedge clock);
    TP = 1'b0; SP = 1'b0;
    repeat (2) @(negedge clock);
    check("tpsp_ack_error", n_ack - ack0, 1);
    check("tpsp_done", n_done - done0, 1);
    check("tpsp_busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
